// File: rtl/perceptron.sv
// Single-neuron processing element: signed fixed-point dot product plus bias,
// rescaled, saturated, passed through ReLU and registered with one cycle of latency.
module perceptron #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] x [N],
   input  logic signed [DATA_WIDTH-1:0] w [N],
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [DATA_WIDTH-1:0] y
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int AW = PW + $clog2(N + 1);

   localparam logic signed [AW-1:0] MAXV = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] MINV = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [PW-1:0]         prod [N];
   logic signed [AW-1:0]         acc;
   logic signed [AW-1:0]         scaled;
   logic signed [DATA_WIDTH-1:0] sat;
   logic signed [DATA_WIDTH-1:0] ynext;

   // The accumulator carries enough guard bits that summing every full-width
   // product with the aligned bias can never wrap.
   always_comb begin
      acc = AW'(b) <<< FRAC_BITS;
      for (int i = 0; i < N; i++) begin
         prod[i] = PW'(x[i]) * PW'(w[i]);
         acc     = acc + AW'(prod[i]);
      end
   end

   // Arithmetic shift truncates toward minus infinity, then clamp and rectify.
   always_comb begin
      scaled = acc >>> FRAC_BITS;
      if (scaled > MAXV) begin
         sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (scaled < MINV) begin
         sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         sat = scaled[DATA_WIDTH-1:0];
      end
      ynext = sat[DATA_WIDTH-1] ? '0 : sat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y <= '0;
      end else begin
         y <= ynext;
      end
   end

endmodule

// File: tb/tb_perceptron.sv
// Directed-vector bench for perceptron (N=4, Q8.8): table-driven vectors plus
// hand-written reset, hold and back-to-back sequences.
module tb_perceptron;

   typedef struct {
      logic [3:0][15:0] xv;
      logic [3:0][15:0] wv;
      logic [15:0]      bv;
      logic [15:0]      expY;
   } vec_t;

   logic               clk;
   logic               rst;
   logic signed [15:0] x [4];
   logic signed [15:0] w [4];
   logic signed [15:0] b;
   logic signed [15:0] y;

   int   tests;
   int   failed;
   vec_t vecs [12];

   perceptron #(.N(4), .DATA_WIDTH(16), .FRAC_BITS(8)) dut (
      .clk (clk),
      .rst (rst),
      .x   (x),
      .w   (w),
      .b   (b),
      .y   (y)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input vec_t v);
      for (int i = 0; i < 4; i++) begin
         x[i] = v.xv[i];
         w[i] = v.wv[i];
      end
      b = v.bv;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] expY);
      tests++;
      if (y !== expY) begin
         failed++;
         $display("[TB] FAIL %s: y=%h expected %h", name, y, expY);
      end
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      clk    = 1'b0;
      rst    = 1'b1;

      // Lane order in the packed literals is {x[3],x[2],x[1],x[0]}.
      vecs[0]  = '{{16'h0400,16'h0300,16'h0200,16'h0100}, {4{16'h0100}}, 16'h0000, 16'h0A00};
      vecs[1]  = '{{4{16'h0100}}, {4{16'hFF00}}, 16'h0000, 16'h0000};
      vecs[2]  = '{{4{16'h0000}}, {4{16'h1234}}, 16'h0180, 16'h0180};
      vecs[3]  = '{{4{16'h0000}}, {4{16'h1234}}, 16'hFF80, 16'h0000};
      vecs[4]  = '{{4{16'h7FFF}}, {4{16'h7FFF}}, 16'h7FFF, 16'h7FFF};
      vecs[5]  = '{{16'h0000,16'h0000,16'h0000,16'h0001}, {16'h0000,16'h0000,16'h0000,16'h0080}, 16'h0000, 16'h0000};
      vecs[6]  = '{{16'h0000,16'h0000,16'h0000,16'h0180}, {4{16'h0100}}, 16'h0080, 16'h0200};
      vecs[7]  = '{{4{16'h0001}}, {4{16'h0080}}, 16'h0000, 16'h0002};
      vecs[8]  = '{{16'h0000,16'h0000,16'hFF00,16'h0200}, {4{16'h0100}}, 16'h0000, 16'h0100};
      vecs[9]  = '{{4{16'h8000}}, {4{16'h7FFF}}, 16'h0000, 16'h0000};
      vecs[10] = '{{4{16'h8000}}, {4{16'h8000}}, 16'h8000, 16'h7FFF};
      vecs[11] = '{{16'h0000,16'h0000,16'h0000,16'hFFFF}, {16'h0000,16'h0000,16'h0000,16'h0080}, 16'h0002, 16'h0001};

      applyStimulus(vecs[0]);
      #1;
      checkOutput("reset_initial", 16'h0000);
      @(posedge clk);
      #1;
      checkOutput("reset_held_over_edge", 16'h0000);

      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(vecs[k]);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d", k), vecs[k].expY);
      end

      applyStimulus(vecs[0]);
      @(posedge clk);
      #1;
      checkOutput("hold_before", 16'h0A00);
      applyStimulus(vecs[2]);
      #2;
      checkOutput("hold_inputs_changed", 16'h0A00);

      rst = 1'b1;
      #1;
      checkOutput("async_reset_mid_cycle", 16'h0000);
      @(posedge clk);
      #1;
      checkOutput("reset_high_over_edge", 16'h0000);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("after_release_no_edge", 16'h0000);
      @(posedge clk);
      #1;
      checkOutput("first_capture_after_reset", 16'h0180);

      applyStimulus(vecs[0]);
      @(posedge clk);
      #1;
      checkOutput("b2b_basic", 16'h0A00);
      applyStimulus(vecs[1]);
      @(posedge clk);
      #1;
      checkOutput("b2b_negative", 16'h0000);
      applyStimulus(vecs[2]);
      @(posedge clk);
      #1;
      checkOutput("b2b_bias", 16'h0180);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
